// File: rtl/ws281x_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ws281x_pkg
// Description : Shared types and constants for the WS281x receive decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package ws281x_pkg;

    // Decoder line states
    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    // A high pulse that lasts this many cycles is a stuck line, not a bit
    localparam int HIGH_CNT_MAX       = 255;

    // GRB 8/8/8
    localparam int PIXEL_BITS_DEFAULT = 24;

endpackage
`default_nettype wire

// File: rtl/ws281x_sync.sv
`default_nettype none
// ============================================================================
// Module      : ws281x_sync
// Description : Two-flop synchronizer for the asynchronous WS281x line, with
//               an optional one-cycle glitch filter (WS281X_DECODE_FILTER_EN)
//               and registered rise/fall edge detection.
// Revision    : 1.0 - initial release
// ============================================================================
module ws281x_sync (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic line_in,
    output logic s_out,
    output logic rise_out,
    output logic fall_out
);

    logic sync1_q;
    logic sync2_q;
    logic s_dly_q;
    logic s;

    // Bring the raw line into the clock domain
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= line_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef WS281X_DECODE_FILTER_EN
    logic prev_q;
    logic filt_q;

    // Follow the synchronized line only after two equal samples in a row
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            prev_q <= 1'b0;
            filt_q <= 1'b0;
        end else begin
            prev_q <= sync2_q;
            if (sync2_q == prev_q) begin
                filt_q <= sync2_q;
            end
        end
    end

    assign s = filt_q;
`else
    assign s = sync2_q;
`endif

    // Previous line value for edge detection
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s_dly_q <= 1'b0;
        end else begin
            s_dly_q <= s;
        end
    end

    assign s_out    = s;
    assign rise_out = s & ~s_dly_q;
    assign fall_out = ~s & s_dly_q;

endmodule
`default_nettype wire

// File: rtl/ws281x_decode.sv
`default_nettype none
// ============================================================================
// Module      : ws281x_decode
// Description : WS281x receive decoder. Measures each high pulse against
//               programmable limits, assembles bits MSB-first into pixel
//               words and detects the inter-frame reset gap.
//               Optional glitch filter: define WS281X_DECODE_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ws281x_decode
    import ws281x_pkg::*;
#(
    parameter int PIXEL_BITS = PIXEL_BITS_DEFAULT,
    parameter int LOW_CNT_W  = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  bit_code_in,
    input  logic [7:0]            t_min_cnt_in,
    input  logic [7:0]            t_thr_cnt_in,
    input  logic [LOW_CNT_W-1:0]  rst_cnt_in,
    output logic                  bit_vld_out,
    output logic                  bit_data_out,
    output logic                  pixel_vld_out,
    output logic [PIXEL_BITS-1:0] pixel_data_out,
    output logic                  rst_det_out,
    output logic                  err_out
);

    localparam int                   BIT_CNT_W    = $clog2(PIXEL_BITS + 1);
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = BIT_CNT_W'(PIXEL_BITS - 1);
    localparam logic [7:0]           HIGH_MAX     = 8'(HIGH_CNT_MAX);

    logic s;
    logic rise;
    logic fall;

    state_t                state_q,     state_d;
    logic [7:0]            high_cnt_q,  high_cnt_d;
    logic [LOW_CNT_W-1:0]  low_cnt_q,   low_cnt_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [PIXEL_BITS-2:0] shift_q,     shift_d;
    logic [PIXEL_BITS-1:0] pixel_q,     pixel_d;
    logic                  bit_vld_q,   bit_vld_d;
    logic                  bit_data_q,  bit_data_d;
    logic                  pixel_vld_q, pixel_vld_d;
    logic                  rst_det_q,   rst_det_d;
    logic                  err_q,       err_d;

    logic                  bit_val;
    logic [PIXEL_BITS-1:0] shift_next;
    logic [LOW_CNT_W-1:0]  low_inc;

    ws281x_sync u_sync (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .line_in  (bit_code_in),
        .s_out    (s),
        .rise_out (rise),
        .fall_out (fall)
    );

    assign bit_val    = (high_cnt_q > t_thr_cnt_in);
    assign shift_next = {shift_q, bit_val};
    assign low_inc    = (low_cnt_q == '1) ? low_cnt_q : low_cnt_q + LOW_CNT_W'(1);

    // Next-state and pulse-output decode
    always_comb begin
        state_d     = state_q;
        high_cnt_d  = high_cnt_q;
        low_cnt_d   = low_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        pixel_d     = pixel_q;
        bit_vld_d   = 1'b0;
        bit_data_d  = 1'b0;
        pixel_vld_d = 1'b0;
        rst_det_d   = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            SYNC: begin
                // Wait for a full low gap before trusting any edge; a zero
                // gap setting never matches because the count saturates
                if (s) begin
                    low_cnt_d = '0;
                end else if (low_inc == rst_cnt_in) begin
                    low_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    low_cnt_d = low_inc;
                end
            end

            IDLE: begin
                if (rise) begin
                    high_cnt_d = 8'd1;
                    state_d    = HIGH;
                end
            end

            HIGH: begin
                if (fall) begin
                    low_cnt_d = LOW_CNT_W'(1);
                    state_d   = LOW;
                    if (high_cnt_q < t_min_cnt_in) begin
                        err_d     = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        bit_vld_d  = 1'b1;
                        bit_data_d = bit_val;
                        shift_d    = shift_next[PIXEL_BITS-2:0];
                        if (bit_cnt_q == BIT_CNT_LAST) begin
                            bit_cnt_d   = '0;
                            pixel_d     = shift_next;
                            pixel_vld_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end
                end else if (high_cnt_q == HIGH_MAX) begin
                    // Stuck-high line: drop the frame and resynchronize
                    err_d     = 1'b1;
                    bit_cnt_d = '0;
                    low_cnt_d = '0;
                    state_d   = SYNC;
                end else begin
                    high_cnt_d = high_cnt_q + 8'd1;
                end
            end

            LOW: begin
                // A new rise takes priority over a coincident gap match
                if (rise) begin
                    high_cnt_d = 8'd1;
                    state_d    = HIGH;
                end else if (low_cnt_q == rst_cnt_in) begin
                    rst_det_d = 1'b1;
                    state_d   = IDLE;
                    if (bit_cnt_q != '0) begin
                        err_d     = 1'b1;
                        bit_cnt_d = '0;
                    end
                end else begin
                    low_cnt_d = low_inc;
                end
            end

            default: begin
                state_d = SYNC;
            end
        endcase
    end

    // State, counters, data path and registered outputs
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= SYNC;
            high_cnt_q  <= '0;
            low_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            pixel_q     <= '0;
            bit_vld_q   <= 1'b0;
            bit_data_q  <= 1'b0;
            pixel_vld_q <= 1'b0;
            rst_det_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            high_cnt_q  <= high_cnt_d;
            low_cnt_q   <= low_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            pixel_q     <= pixel_d;
            bit_vld_q   <= bit_vld_d;
            bit_data_q  <= bit_data_d;
            pixel_vld_q <= pixel_vld_d;
            rst_det_q   <= rst_det_d;
            err_q       <= err_d;
        end
    end

    assign bit_vld_out    = bit_vld_q;
    assign bit_data_out   = bit_data_q;
    assign pixel_vld_out  = pixel_vld_q;
    assign pixel_data_out = pixel_q;
    assign rst_det_out    = rst_det_q;
    assign err_out        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ws281x_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_ws281x_decode
// Description : Self-checking bench for ws281x_decode. Drives pulse trains on
//               the line and compares every output pulse against a pulse-level
//               reference model of the protocol.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ws281x_decode;

    localparam int PB      = 24;
    localparam int LW      = 16;
    localparam int T_MIN   = 2;
    localparam int T_THR   = 6;
    localparam int RST_CNT = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          line = 1'b0;
    logic          bit_vld;
    logic          bit_data;
    logic          pixel_vld;
    logic [PB-1:0] pixel_data;
    logic          rst_det;
    logic          err;

    always #5 clk = ~clk;

    ws281x_decode #(
        .PIXEL_BITS (PB),
        .LOW_CNT_W  (LW)
    ) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .bit_code_in    (line),
        .t_min_cnt_in   (8'(T_MIN)),
        .t_thr_cnt_in   (8'(T_THR)),
        .rst_cnt_in     (LW'(RST_CNT)),
        .bit_vld_out    (bit_vld),
        .bit_data_out   (bit_data),
        .pixel_vld_out  (pixel_vld),
        .pixel_data_out (pixel_data),
        .rst_det_out    (rst_det),
        .err_out        (err)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Event record: {bit_vld, bit_data, pixel_vld, pixel_data, rst_det, err}
    logic [28:0] dut_ev[$];
    int          dut_cyc[$];
    logic [28:0] exp_ev[$];

    // Reference model state
    bit          m_synced;
    bit          m_in_low;
    int          m_bits;
    logic [23:0] m_acc;
    logic [23:0] m_pix;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every cycle with any output pulse
    always @(negedge clk) begin
        if (bit_vld | pixel_vld | rst_det | err) begin
            dut_ev.push_back({bit_vld, bit_vld & bit_data, pixel_vld,
                              (pixel_vld ? pixel_data : 24'd0), rst_det, err});
            dut_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_synced = 1'b0;
        m_in_low = 1'b0;
        m_bits   = 0;
        m_acc    = '0;
        m_pix    = '0;
    endtask

    // One high pulse of h cycles
    task automatic model_pulse(input int h);
        bit b;
        if (!m_synced) return;
`ifdef WS281X_DECODE_FILTER_EN
        if (h < 2) return;
`endif
        if (h > 255) begin
            exp_ev.push_back({28'd0, 1'b1});
            m_bits   = 0;
            m_synced = 1'b0;
            m_in_low = 1'b0;
            return;
        end
        m_in_low = 1'b1;
        if (h < T_MIN) begin
            exp_ev.push_back({28'd0, 1'b1});
            m_bits = 0;
        end else begin
            b     = (h > T_THR);
            m_acc = {m_acc[22:0], b};
            m_bits++;
            if (m_bits == PB) begin
                m_bits = 0;
                m_pix  = m_acc;
                exp_ev.push_back({1'b1, b, 1'b1, m_acc, 2'b00});
            end else begin
                exp_ev.push_back({1'b1, b, 1'b0, 24'd0, 2'b00});
            end
        end
    endtask

    // A low stretch of l cycles following whatever came before
    task automatic model_low(input int l);
        if (!m_synced) begin
            if (l >= RST_CNT) m_synced = 1'b1;
        end else if (m_in_low && l > RST_CNT) begin
            exp_ev.push_back({27'd0, 1'b1, (m_bits != 0)});
            m_bits   = 0;
            m_in_low = 1'b0;
        end
    endtask

    task automatic drive(input int h, input int l);
        model_pulse(h);
        model_low(l);
        line = 1'b1;
        repeat (h) @(negedge clk);
        line = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic gap(input int l);
        model_low(l);
        line = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic send_word(input logic [23:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            if (w[i]) drive(10, 4);
            else      drive(4, 8);
        end
    endtask

    task automatic flush_check(input string tag);
        line = 1'b0;
        repeat (8) @(negedge clk);
        check_eq({tag, "_count"}, dut_ev.size(), exp_ev.size());
        for (int i = 0; i < dut_ev.size() && i < exp_ev.size(); i++) begin
            check_eq($sformatf("%s_ev%0d", tag, i), dut_ev[i], exp_ev[i]);
        end
        dut_ev.delete();
        dut_cyc.delete();
        exp_ev.delete();
    endtask

    initial begin
        logic [23:0] w;
        int          h;
        int          l;
        int          n;

        model_reset();
        rst_n = 1'b0;
        line  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_bit_vld",   bit_vld,    0);
        check_eq("rst_pixel_vld", pixel_vld,  0);
        check_eq("rst_pixel",     pixel_data, 0);
        check_eq("rst_rst_det",   rst_det,    0);
        check_eq("rst_err",       err,        0);
        rst_n = 1'b1;

        // Initial sync, then single bits and threshold boundaries
        gap(120);
        drive(4, 8);
        flush_check("bit0");
        drive(10, 4);
        drive(6, 5);
        drive(7, 5);
        flush_check("thr");
        gap(120);
        flush_check("align");

        // Known pixel and reset gap latency
        send_word(24'hA5C33C, 24);
        gap(120);
        check_eq("rst_lat",
                 (dut_ev.size() >= 25) ? 64'(dut_cyc[24] - dut_cyc[23]) : 64'd0,
                 RST_CNT);
        check_eq("pix_out", pixel_data, 24'hA5C33C);
        flush_check("pix");

        // Partial pixel discarded at the gap, then a clean pixel
        send_word(24'h3FF, 10);
        gap(120);
        send_word(24'h1E2D3C, 24);
        gap(120);
        flush_check("partial");

        // Single-cycle high pulse
        drive(1, 6);
        flush_check("glitch");

        // Randomized pulse trains
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(20, 40);
            for (int k = 0; k < n; k++) begin
                h = ($urandom_range(0, 11) == 0) ? 1 : $urandom_range(2, 20);
                l = $urandom_range(2, 15);
                drive(h, l);
            end
            gap(120);
            flush_check($sformatf("rnd%0d", r));
        end

        // Stuck-high line, pulses ignored until a full gap
        drive(300, 5);
        drive(4, 8);
        drive(10, 4);
        gap(120);
        flush_check("ovf");
        send_word(24'h5A5A5A, 24);
        gap(120);
        flush_check("ovf_pix");

        // Reset mid-pixel
        w = 24'($urandom);
        send_word(w, 10);
        flush_check("pre_rst");
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("mid_rst_pixel",   pixel_data, 0);
        check_eq("mid_rst_bit_vld", bit_vld,    0);
        check_eq("mid_rst_err",     err,        0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4, 8);
        drive(10, 4);
        gap(120);
        w = 24'($urandom);
        send_word(w, 24);
        gap(120);
        flush_check("post_rst");
        check_eq("pix_hold", pixel_data, m_pix);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
